// File: rtl/vedic8_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vedic8_seq_ctrl_if
// Brief    : Operand/product handshake bundle for the sequential 8x8 multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface vedic8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );
endinterface
`default_nettype wire

// File: rtl/vedic8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vedic8_seq_ctrl
// Brief    : 8x8 unsigned multiplier built by time-multiplexing one Vedic 4x4
//            core over four partial-product phases, with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================

// Urdhva-tiryak 2x2 cell: crosswise terms summed with half adders.
module vedic_2x2 (
    input  wire logic [1:0] i_x,
    input  wire logic [1:0] i_y,
    output logic      [3:0] o_p
);
    logic w_t1, w_t2, w_t3, w_c1;

    always_comb begin
        w_t1   = i_x[1] & i_y[0];
        w_t2   = i_x[0] & i_y[1];
        w_t3   = i_x[1] & i_y[1];
        w_c1   = w_t1 & w_t2;
        o_p[0] = i_x[0] & i_y[0];
        o_p[1] = w_t1 ^ w_t2;
        o_p[2] = w_t3 ^ w_c1;
        o_p[3] = w_t3 & w_c1;
    end
endmodule

module vedic_4x4 (
    input  wire logic [3:0] i_x,
    input  wire logic [3:0] i_y,
    output logic      [7:0] o_p
);
    logic [3:0] w_q0, w_q1, w_q2, w_q3;

    vedic_2x2 u_q0 (.i_x(i_x[1:0]), .i_y(i_y[1:0]), .o_p(w_q0));
    vedic_2x2 u_q1 (.i_x(i_x[3:2]), .i_y(i_y[1:0]), .o_p(w_q1));
    vedic_2x2 u_q2 (.i_x(i_x[1:0]), .i_y(i_y[3:2]), .o_p(w_q2));
    vedic_2x2 u_q3 (.i_x(i_x[3:2]), .i_y(i_y[3:2]), .o_p(w_q3));

    assign o_p = {4'b0000, w_q0} + {2'b00, w_q1, 2'b00}
               + {2'b00, w_q2, 2'b00} + {w_q3, 4'b0000};
endmodule

module vedic8_seq_ctrl #(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vedic8_seq_ctrl_if.slave  io_bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [1:0]  r_phase;

    logic        w_accept;
    logic        w_zero;
    logic [3:0]  w_x;
    logic [3:0]  w_y;
    logic [7:0]  w_prod;
    logic [15:0] w_pp;

    assign w_accept = io_bus.in_valid && (r_state == S_IDLE);
    assign w_zero   = ZERO_SKIP && ((io_bus.a == 8'h00) || (io_bus.b == 8'h00));

    // Phase bit 0 picks the multiplicand nibble, bit 1 the multiplier nibble.
    assign w_x = r_phase[0] ? r_a[7:4] : r_a[3:0];
    assign w_y = r_phase[1] ? r_b[7:4] : r_b[3:0];

    vedic_4x4 u_core (.i_x(w_x), .i_y(w_y), .o_p(w_prod));

    always_comb begin
        w_pp = 16'h0000;
        case (r_phase)
            2'd0:    w_pp = {8'h00, w_prod};
            2'd1,
            2'd2:    w_pp = {4'h0, w_prod, 4'h0};
            default: w_pp = {w_prod, 8'h00};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero ? S_DONE : S_MUL;
                end
            end
            S_MUL: begin
                if (r_phase == 2'd3) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (io_bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_acc   <= 16'h0000;
            r_phase <= 2'd0;
        end else if (w_accept) begin
            r_a     <= io_bus.a;
            r_b     <= io_bus.b;
            r_acc   <= 16'h0000;
            r_phase <= 2'd0;
        end else if (r_state == S_MUL) begin
            r_acc   <= r_acc + w_pp;
            r_phase <= r_phase + 2'd1;
        end
    end

    // in_ready is held low for the whole time reset is asserted.
    always_comb begin
        io_bus.in_ready  = (r_state == S_IDLE) && !rst;
        io_bus.out_valid = (r_state == S_DONE);
        io_bus.busy      = (r_state != S_IDLE);
        io_bus.p         = r_acc;
    end
endmodule
`default_nettype wire

// File: tb/tb_vedic8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vedic8_seq_ctrl
// Brief    : Scoreboard bench: randomized operands against a*b, with stalls,
//            zero-skip, hold-while-stalled and mid-operation reset scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vedic8_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vedic8_seq_ctrl_if bus ();
    vedic8_seq_ctrl_if bus0 ();

    vedic8_seq_ctrl #(.ZERO_SKIP(1'b1)) dut  (.clk(clk), .rst(rst), .io_bus(bus.slave));
    vedic8_seq_ctrl #(.ZERO_SKIP(1'b0)) dut0 (.clk(clk), .rst(rst), .io_bus(bus0.slave));

    typedef struct {
        logic [15:0] p;
        int          rise;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   rdy_mode = 1;
    bit   stuck  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'b0;
        endcase
    end

    // Monitor: sampled mid-cycle, pops the scoreboard on each handoff.
    logic        prev_v = 1'b0;
    logic [15:0] held_p = 16'h0000;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rst_valid actual=%b required=0", bus.out_valid);
            end
        end else begin
            checks++;
            if (bus.busy !== !bus.in_ready) begin
                fails++;
                $display("FAIL busy_vs_ready busy=%b in_ready=%b required opposite", bus.busy, bus.in_ready);
            end
            if (bus.out_valid && !prev_v) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_valid actual out_valid=1 required=0 (no outstanding op)");
                end else if (cyc != q[0].rise) begin
                    fails++;
                    $display("FAIL latency actual edge=%0d required edge=%0d", cyc, q[0].rise);
                end
            end
            if (bus.out_valid && prev_v) begin
                checks++;
                if (bus.p !== held_p || bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL hold actual p=%h busy=%b required p=%h busy=1", bus.p, bus.busy, held_p);
                end
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.p !== e.p) begin
                    fails++;
                    $display("FAIL product actual=%h required=%h", bus.p, e.p);
                end
            end
            prev_v = bus.out_valid;
            held_p = bus.p;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Offer one pair; unrelated in_valid noise is driven while the block is busy.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int g = 0;
        if (stuck) return;
        while (!bus.in_ready) begin
            bus.in_valid = $urandom_range(0, 1);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(posedge clk); #1;
            g++;
            if (g > 30) begin
                checks++;
                fails++;
                stuck = 1'b1;
                $display("FAIL in_ready_timeout actual=0 required=1");
                return;
            end
        end
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        // Accept edge is the next one; the multiply path adds four phase edges.
        q.push_back('{16'(int'(a) * int'(b)),
                      cyc + 1 + (((a == 0) || (b == 0)) ? 0 : 4)});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int g = 0;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain outstanding=%0d required=0", q.size());
        end
    endtask

    initial begin
        int g;
        logic [7:0] ra, rb;
        logic [7:0] ca [6];
        logic [7:0] cb [6];
        ca = '{8'hFF, 8'h00, 8'h01, 8'hFF, 8'h80, 8'h0F};
        cb = '{8'hFF, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hF0};

        bus.in_valid = 1'b0;  bus.a = 8'h00;  bus.b = 8'h00;  bus.out_ready = 1'b1;
        bus0.in_valid = 1'b0; bus0.a = 8'h00; bus0.b = 8'h00; bus0.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("in_ready_in_rst", 16'(bus.in_ready), 16'h0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 16'(bus.in_ready), 16'h1);
        check("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_p", bus.p, 16'h0000);
        @(posedge clk); #1;

        rdy_mode = 1;
        issue(8'hFF, 8'hFF);
        drain();
        check("ff_ff_idle", 16'(bus.in_ready), 16'h1);

        issue(8'h00, 8'h5A);
        drain();

        // Same zero operand with zero-skip disabled must go the long way.
        bus0.in_valid = 1'b1; bus0.a = 8'h00; bus0.b = 8'h5A;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        g = 0;
        while (!bus0.out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("noskip_latency", 16'(g), 16'd4);
        check("noskip_p", bus0.p, 16'h0000);
        @(posedge clk); #1;
        check("noskip_idle", 16'(bus0.busy), 16'h0);

        rdy_mode = 2;
        issue(8'h3C, 8'hA7);
        bus.in_valid = 1'b0;
        g = 0;
        while (!bus.out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("stall_valid", 16'(bus.out_valid), 16'h1);
        repeat (3) begin
            bus.in_valid = 1'b1;
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(posedge clk); #1;
        end
        check("stall_p", bus.p, 16'h2724);
        check("stall_busy", 16'(bus.busy), 16'h1);
        bus.in_valid = 1'b0;
        rdy_mode = 1;
        drain();

        issue(8'h12, 8'h34);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("mid_rst_p", bus.p, 16'h0000);
        check("mid_rst_valid", 16'(bus.out_valid), 16'h0);
        check("mid_rst_busy", 16'(bus.busy), 16'h0);
        check("mid_rst_ready", 16'(bus.in_ready), 16'h0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", 16'(bus.in_ready), 16'h1);
        issue(8'h02, 8'h03);
        drain();

        for (int i = 0; i < 6; i++) begin
            issue(ca[i], cb[i]);
        end
        drain();

        rdy_mode = 0;
        for (int i = 0; i < 1500; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            issue(ra, rb);
        end
        rdy_mode = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
